// File: rtl/crp16_rf_writeback_arbiter.sv
// CRP16 register-file writeback arbiter: round-robin over ALU/load/CSR.
// Optional busy scoreboard enabled by CRP16_RF_WB_SCOREBOARD_EN.
module crp16_rf_writeback_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 3,
  parameter int NUM_REQ    = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]    req_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_val,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rf_write,
  output logic [SEL_WIDTH-1:0]            rf_write_sel,
  output logic [DATA_WIDTH-1:0]           rf_write_val,
  input  logic                            rsv_valid,
  input  logic [SEL_WIDTH-1:0]            rsv_sel,
  output logic [(1<<SEL_WIDTH)-1:0]       busy
);

  logic [1:0]            ptr;
  logic [1:0]            gidx;
  logic                  hit;
  logic [SEL_WIDTH-1:0]  sel_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] val_a [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a[i] = req_sel[i*SEL_WIDTH +: SEL_WIDTH];
      val_a[i] = req_val[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search order starts at ptr and wraps over the three requesters.
  always_comb begin
    gidx = 2'd0;
    hit  = !reset && (|req_valid);
    unique case (ptr)
      2'd1: gidx = req_valid[1] ? 2'd1 :
                   req_valid[2] ? 2'd2 : 2'd0;
      2'd2: gidx = req_valid[2] ? 2'd2 :
                   req_valid[0] ? 2'd0 : 2'd1;
      default: gidx = req_valid[0] ? 2'd0 :
                      req_valid[1] ? 2'd1 : 2'd2;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (hit) req_ready[gidx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr          <= 2'd0;
      rf_write     <= 1'b0;
      rf_write_sel <= '0;
      rf_write_val <= '0;
    end else if (hit) begin
      ptr          <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
      rf_write     <= 1'b1;
      rf_write_sel <= sel_a[gidx];
      rf_write_val <= val_a[gidx];
    end else begin
      rf_write     <= 1'b0;
    end
  end

`ifdef CRP16_RF_WB_SCOREBOARD_EN
  logic [(1<<SEL_WIDTH)-1:0] busy_q;
  logic [(1<<SEL_WIDTH)-1:0] busy_d;

  // Clear first so a same-index reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_write)  busy_d[rf_write_sel] = 1'b0;
    if (rsv_valid) busy_d[rsv_sel]      = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_sel};
  assign busy = '0;
`endif

endmodule
